// File: rtl/dino_game_pkg.sv
// Shared types, geometry defaults and datapath widths for the dino game engine.
package dino_game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } game_state_e;

    localparam int COORD_W = 12;
    localparam int VEL_W   = 8;
    localparam int SCORE_W = 16;
    localparam int SUM_W   = 13;
    localparam int CNT_W   = 8;

    localparam logic [COORD_W-1:0] DINO_X       = 12'd240;
    localparam logic [COORD_W-1:0] GROUND_Y     = 12'd320;
    localparam logic [COORD_W-1:0] OBST_START_X = 12'd680;

endpackage

// File: rtl/dino_game_engine_rise_pulse.sv
// Registered rising-edge detector: one-clk pulse the cycle after the input rises.
module rise_pulse (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev_r;
    logic pulse_r;

    // Track previous level and register the edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            prev_r  <= in;
            pulse_r <= in & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/dino_game_engine.sv
// Per-frame game state for the dino runner: jump physics, obstacle scroll,
// run/pause/over state machine and score, all advanced once per frame tick.
module dino_game_engine
    import dino_game_pkg::*;
#(
    parameter int unsigned JUMP_V         = 32'd14,
    parameter int unsigned GRAVITY        = 32'd1,
    parameter int unsigned SPEED_INIT     = 32'd4,
    parameter int unsigned SPEED_MAX      = 32'd12,
    parameter int unsigned SPEED_UP_EVERY = 32'd5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               screen_ready,
    input  logic               collision_detected,
    input  logic               jump_btn,
    input  logic               pause_btn,
    output logic [31:0]        x_coor,
    output logic [31:0]        y_coor,
    output logic [31:0]        x_coor_obstacle,
    output logic [31:0]        y_coor_obstacle,
    output logic               game_over,
    output logic               pause,
    output logic [SCORE_W-1:0] score
);

    logic tick_s, jump_p_s, pause_p_s;

    rise_pulse u_tick  (.clk(clk), .reset(reset), .in(screen_ready), .pulse(tick_s));
    rise_pulse u_jump  (.clk(clk), .reset(reset), .in(jump_btn),     .pulse(jump_p_s));
    rise_pulse u_pause (.clk(clk), .reset(reset), .in(pause_btn),    .pulse(pause_p_s));

    game_state_e               state_r, state_next_s;
    logic                      game_over_r, game_over_s, pause_r, pause_s;
    logic [COORD_W-1:0]        y_r, y_next_s, x_obs_r, x_obs_next_s, speed_r, speed_next_s;
    logic signed [VEL_W-1:0]   vel_r, vel_next_s;
    logic [CNT_W-1:0]          cleared_r, cleared_next_s;
    logic [SCORE_W-1:0]        score_r, score_next_s;
    logic                      jump_req_r, jump_req_next_s;
    logic signed [SUM_W-1:0]   ny_s;
    logic                      update_s, grounded_s;

    // State and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            game_over_r <= 1'b0;
            pause_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            game_over_r <= game_over_s;
            pause_r     <= pause_s;
        end
    end

    // Next-state: collision outranks pause, pause outranks a plain tick.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = jump_p_s ? RUN : IDLE;
            RUN: begin
                if (tick_s && collision_detected) begin
                    state_next_s = OVER;
                end else if (pause_p_s) begin
                    state_next_s = PAUSED;
                end else begin
                    state_next_s = RUN;
                end
            end
            PAUSED:  state_next_s = pause_p_s ? RUN : PAUSED;
            OVER:    state_next_s = jump_p_s ? IDLE : OVER;
            default: state_next_s = IDLE;
        endcase
    end

    // Status flags decoded from the state being entered so they register with it.
    always_comb begin
        game_over_s = 1'b0;
        pause_s     = 1'b0;
        case (state_next_s)
            OVER:    game_over_s = 1'b1;
            PAUSED:  pause_s     = 1'b1;
            default: begin
                game_over_s = 1'b0;
                pause_s     = 1'b0;
            end
        endcase
    end

    assign update_s   = (state_r == RUN) && tick_s && !collision_detected && !pause_p_s;
    assign grounded_s = (y_r == GROUND_Y) && (vel_r == 8'sd0);
    assign ny_s       = $signed({1'b0, y_r}) - $signed({{(SUM_W-VEL_W){vel_r[VEL_W-1]}}, vel_r});

    // Physics, obstacle and score next values; entering IDLE restores start values.
    always_comb begin
        y_next_s        = y_r;
        vel_next_s      = vel_r;
        x_obs_next_s    = x_obs_r;
        speed_next_s    = speed_r;
        cleared_next_s  = cleared_r;
        score_next_s    = score_r;
        jump_req_next_s = jump_req_r;
        if (state_next_s == IDLE) begin
            y_next_s        = GROUND_Y;
            vel_next_s      = 8'sd0;
            x_obs_next_s    = OBST_START_X;
            speed_next_s    = COORD_W'(SPEED_INIT);
            cleared_next_s  = 8'd0;
            score_next_s    = 16'd0;
            jump_req_next_s = 1'b0;
        end else begin
            if (state_r == RUN && tick_s) begin
                jump_req_next_s = 1'b0;
            end else if (state_r == RUN && jump_p_s) begin
                jump_req_next_s = 1'b1;
            end else begin
                jump_req_next_s = jump_req_r;
            end
            if (update_s) begin
                if (grounded_s && jump_req_r) begin
                    vel_next_s = VEL_W'(JUMP_V);
                end else if (ny_s >= $signed({1'b0, GROUND_Y})) begin
                    y_next_s   = GROUND_Y;
                    vel_next_s = 8'sd0;
                end else begin
                    y_next_s   = ny_s[COORD_W-1:0];
                    vel_next_s = vel_r - VEL_W'(GRAVITY);
                end
                if (x_obs_r <= speed_r) begin
                    x_obs_next_s = OBST_START_X;
                    score_next_s = (score_r == 16'hFFFF) ? score_r : score_r + 16'd1;
                    if (cleared_r == CNT_W'(SPEED_UP_EVERY - 32'd1)) begin
                        cleared_next_s = 8'd0;
                        speed_next_s   = (speed_r < COORD_W'(SPEED_MAX)) ? speed_r + 12'd1
                                                                         : COORD_W'(SPEED_MAX);
                    end else begin
                        cleared_next_s = cleared_r + 8'd1;
                    end
                end else begin
                    x_obs_next_s = x_obs_r - speed_r;
                end
            end else begin
                y_next_s = y_r;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_r        <= GROUND_Y;
            vel_r      <= 8'sd0;
            x_obs_r    <= OBST_START_X;
            speed_r    <= COORD_W'(SPEED_INIT);
            cleared_r  <= 8'd0;
            score_r    <= 16'd0;
            jump_req_r <= 1'b0;
        end else begin
            y_r        <= y_next_s;
            vel_r      <= vel_next_s;
            x_obs_r    <= x_obs_next_s;
            speed_r    <= speed_next_s;
            cleared_r  <= cleared_next_s;
            score_r    <= score_next_s;
            jump_req_r <= jump_req_next_s;
        end
    end

    assign x_coor          = {{(32-COORD_W){1'b0}}, DINO_X};
    assign y_coor          = {{(32-COORD_W){1'b0}}, y_r};
    assign x_coor_obstacle = {{(32-COORD_W){1'b0}}, x_obs_r};
    assign y_coor_obstacle = {{(32-COORD_W){1'b0}}, GROUND_Y};
    assign game_over       = game_over_r;
    assign pause           = pause_r;
    assign score           = score_r;

endmodule

// File: tb/tb_dino_game_engine.sv
// Scoreboard bench for dino_game_engine: directed frame ticks and button presses,
// hand-computed expected positions queued and checked by an independent monitor.
module tb_dino_game_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        screen_ready = 1'b0;
    logic        collision_detected = 1'b0;
    logic        jump_btn = 1'b0;
    logic        pause_btn = 1'b0;
    logic [31:0] x_coor, y_coor, x_coor_obstacle, y_coor_obstacle;
    logic        game_over, pause;
    logic [15:0] score;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] y;
        logic [31:0] xo;
        logic        go;
        logic        ps;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];

    dino_game_engine dut (
        .clk(clk), .reset(reset), .screen_ready(screen_ready),
        .collision_detected(collision_detected), .jump_btn(jump_btn), .pause_btn(pause_btn),
        .x_coor(x_coor), .y_coor(y_coor), .x_coor_obstacle(x_coor_obstacle),
        .y_coor_obstacle(y_coor_obstacle), .game_over(game_over), .pause(pause), .score(score)
    );

    always #5 clk = ~clk;

    // Monitor: compare outputs against every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (y_coor !== e.y || x_coor_obstacle !== e.xo || game_over !== e.go ||
                    pause !== e.ps || score !== e.sc || x_coor !== 32'd240 ||
                    y_coor_obstacle !== 32'd320) begin
                    failures++;
                    $display("FAIL %s: got y=%0d xo=%0d go=%0d p=%0d sc=%0d x=%0d yo=%0d, want y=%0d xo=%0d go=%0d p=%0d sc=%0d x=240 yo=320",
                             e.name, y_coor, x_coor_obstacle, game_over, pause, score, x_coor,
                             y_coor_obstacle, e.y, e.xo, e.go, e.ps, e.sc);
                end
            end
        end
    end

    task automatic expect_out(input string name, input int y, input int xo,
                              input logic go, input logic ps, input int sc);
        exp_t e;
        e.name = name;
        e.y    = 32'(y);
        e.xo   = 32'(xo);
        e.go   = go;
        e.ps   = ps;
        e.sc   = 16'(sc);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic col, input logic pz);
        screen_ready       = 1'b1;
        collision_detected = col;
        pause_btn          = pz;
        cyc(3);
        screen_ready = 1'b0;
        pause_btn    = 1'b0;
        cyc(3);
        collision_detected = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic press_jump();
        jump_btn = 1'b1;
        cyc(2);
        jump_btn = 1'b0;
        cyc(2);
    endtask

    task automatic press_pause();
        pause_btn = 1'b1;
        cyc(2);
        pause_btn = 1'b0;
        cyc(2);
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        cyc(1);
        expect_out("reset", 320, 680, 1'b0, 1'b0, 0);
        ticks(10);
        expect_out("idle_ticks", 320, 680, 1'b0, 1'b0, 0);

        // Start and scroll at initial speed.
        press_jump();
        ticks(3);
        expect_out("run_3", 320, 668, 1'b0, 1'b0, 0);
        ticks(166);
        expect_out("run_169", 320, 4, 1'b0, 1'b0, 0);
        ticks(1);
        expect_out("wrap_1", 320, 680, 1'b0, 1'b0, 1);
        ticks(680);
        expect_out("wrap_5", 320, 680, 1'b0, 1'b0, 5);
        ticks(1);
        expect_out("speed_5", 320, 675, 1'b0, 1'b0, 5);

        // Jump arc, with a press at the apex that must be ignored.
        press_jump();
        tick(1'b0, 1'b0);
        expect_out("jump_launch", 320, 670, 1'b0, 1'b0, 5);
        tick(1'b0, 1'b0);
        expect_out("jump_rise", 306, 665, 1'b0, 1'b0, 5);
        ticks(14);
        expect_out("jump_apex", 215, 595, 1'b0, 1'b0, 5);
        press_jump();
        ticks(13);
        expect_out("jump_fall", 306, 530, 1'b0, 1'b0, 5);
        tick(1'b0, 1'b0);
        expect_out("jump_land", 320, 525, 1'b0, 1'b0, 5);
        tick(1'b0, 1'b0);
        expect_out("no_rejump", 320, 520, 1'b0, 1'b0, 5);

        // Pause coinciding with a tick wins; ticks ignored while paused.
        tick(1'b0, 1'b1);
        expect_out("pause_tick", 320, 520, 1'b0, 1'b1, 5);
        ticks(20);
        expect_out("paused_hold", 320, 520, 1'b0, 1'b1, 5);
        press_pause();
        expect_out("unpause", 320, 520, 1'b0, 1'b0, 5);
        tick(1'b0, 1'b0);
        expect_out("resume", 320, 515, 1'b0, 1'b0, 5);

        // Collision freezes positions; only jump leaves OVER.
        tick(1'b1, 1'b0);
        expect_out("collide", 320, 515, 1'b1, 1'b0, 5);
        ticks(3);
        expect_out("over_hold", 320, 515, 1'b1, 1'b0, 5);
        press_pause();
        expect_out("over_pause_ign", 320, 515, 1'b1, 1'b0, 5);
        press_jump();
        expect_out("over_to_idle", 320, 680, 1'b0, 1'b0, 0);

        // Reset mid-jump.
        press_jump();
        press_jump();
        tick(1'b0, 1'b0);
        expect_out("rj_launch", 320, 676, 1'b0, 1'b0, 0);
        ticks(6);
        expect_out("rj_mid", 251, 652, 1'b0, 1'b0, 0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        expect_out("rj_reset", 320, 680, 1'b0, 1'b0, 0);
        ticks(2);
        expect_out("rj_idle", 320, 680, 1'b0, 1'b0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
